// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared constants for the I/D memory arbiter
package mem_arbiter_pkg;

    // FSM encodings (2-bit, legacy-compatible constants)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Owner of the access currently in flight
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int AW_DEFAULT      = 16;
    localparam int DW_DEFAULT      = 16;
    localparam int TIMEOUT_DEFAULT = 64;

    // Watchdog counter width; TIMEOUT must be at least 2
    function automatic int wdog_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-side bundle of the I/D arbiter
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic          i_stall;

    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          d_stall;

    logic          flush;

    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_done;

    logic          err;

    // Arbiter view
    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, flush,
               mem_rdata, mem_done,
        output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
               mem_en, mem_wr, mem_addr, mem_wdata, err
    );

    // Pipeline + memory view
    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, flush,
               mem_rdata, mem_done,
        input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
               mem_en, mem_wr, mem_addr, mem_wdata, err
    );

endinterface

// File: rtl/mem_arbiter_timeout_ctr.sv
// rtl/mem_arbiter_timeout_ctr.sv - watchdog counter for the WAIT state
module arb_timeout_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int            CW     = wdog_width(TIMEOUT);
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // Holds at terminal count so a stuck enable cannot wrap back to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter, D-side over I-side priority
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = AW_DEFAULT,
    parameter int DW      = DW_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_arbiter_if.slave bus
);
    logic [1:0]    r_state;
    logic          r_owner;
    logic          r_drop;
    logic          r_err;
    logic          r_mem_en;
    logic          r_mem_wr;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          r_i_done;
    logic          r_d_done;

    logic w_flush_i;
    logic w_drop_now;
    logic w_wdog_clr;
    logic w_wdog_en;
    logic w_wdog_tc;

    // A redirect only matters while a fetch owns the memory
    assign w_flush_i  = bus.flush && (r_owner == OWN_I) && (r_state != ST_IDLE);
    assign w_drop_now = r_drop || w_flush_i;

    assign w_wdog_clr = (r_state == ST_ISSUE);
    assign w_wdog_en  = (r_state == ST_WAIT);

    arb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_wdog_clr),
        .i_en  (w_wdog_en),
        .o_tc  (w_wdog_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_I;
            r_drop      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
        end else begin
            r_mem_en <= 1'b0;
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            if (w_flush_i) begin
                r_drop <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.d_req) begin
                        r_state     <= ST_ISSUE;
                        r_owner     <= OWN_D;
                        r_drop      <= 1'b0;
                        r_mem_en    <= 1'b1;
                        r_mem_wr    <= bus.d_wr;
                        r_mem_addr  <= bus.d_addr;
                        r_mem_wdata <= bus.d_wdata;
                    end else if (bus.i_req && !bus.flush) begin
                        r_state    <= ST_ISSUE;
                        r_owner    <= OWN_I;
                        r_drop     <= 1'b0;
                        r_mem_en   <= 1'b1;
                        r_mem_wr   <= 1'b0;
                        r_mem_addr <= bus.i_addr;
                    end
                end

                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end

                // Done is registered here, so a flush in the completing
                // cycle still suppresses the fetch response.
                ST_WAIT: begin
                    if (bus.mem_done) begin
                        r_state <= ST_RESP;
                        if (r_owner == OWN_D) begin
                            r_d_rdata <= bus.mem_rdata;
                            r_d_done  <= 1'b1;
                        end else if (!w_drop_now) begin
                            r_i_rdata <= bus.mem_rdata;
                            r_i_done  <= 1'b1;
                        end
                    end else if (w_wdog_tc) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end

                ST_RESP: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.i_done    = r_i_done;
    assign bus.d_done    = r_d_done;
    assign bus.err       = r_err;

    assign bus.i_stall   = bus.i_req && !r_i_done;
    assign bus.d_stall   = bus.d_req && !r_d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;

    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(16), .DW(16)) bus();

    mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] mrdata;
        logic        exp_wr;
        logic [15:0] exp_rdata;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int n_idone  = 0;
    int n_ddone  = 0;

    logic [15:0] last_i;
    logic [15:0] last_d;
    logic        last_d_ok;

    always @(negedge clk) begin
        if (bus.i_done === 1'b1) n_idone++;
        if (bus.d_done === 1'b1) n_ddone++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_wr      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.flush     = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_done  = 1'b0;
    endtask

    task automatic run_access(input vec_t v, input string tag);
        int c0i;
        int c0d;
        c0i = n_idone;
        c0d = n_ddone;
        if (v.is_d) begin
            bus.d_req   = 1'b1;
            bus.d_wr    = v.wr;
            bus.d_addr  = v.addr;
            bus.d_wdata = v.wdata;
        end else begin
            bus.i_req  = 1'b1;
            bus.i_addr = v.addr;
        end
        settle();
        chk({tag, " stall_at_req"}, v.is_d ? bus.d_stall : bus.i_stall, 1);
        chk({tag, " mem_en_idle"}, bus.mem_en, 0);
        tick();
        settle();
        chk({tag, " mem_en_issue"}, bus.mem_en, 1);
        chk({tag, " mem_wr"}, bus.mem_wr, v.exp_wr);
        chk({tag, " mem_addr"}, bus.mem_addr, v.addr);
        if (v.is_d && v.wr) chk({tag, " mem_wdata"}, bus.mem_wdata, v.wdata);
        tick();
        for (int k = 1; k <= v.lat; k++) begin
            bus.mem_done  = (k == v.lat);
            bus.mem_rdata = (k == v.lat) ? v.mrdata : 16'h0BAD;
            settle();
            chk({tag, " done_early"}, v.is_d ? bus.d_done : bus.i_done, 0);
            if (k == v.lat) chk({tag, " stall_wait"}, v.is_d ? bus.d_stall : bus.i_stall, 1);
            tick();
        end
        bus.mem_done = 1'b0;
        settle();
        chk({tag, " done"}, v.is_d ? bus.d_done : bus.i_done, 1);
        chk({tag, " stall_done"}, v.is_d ? bus.d_stall : bus.i_stall, 0);
        chk({tag, " addr_hold"}, bus.mem_addr, v.addr);
        chk({tag, " wr_hold"}, bus.mem_wr, v.exp_wr);
        if (!(v.is_d && v.wr)) chk({tag, " rdata"}, v.is_d ? bus.d_rdata : bus.i_rdata, v.exp_rdata);
        if (v.is_d) chk({tag, " i_rdata_hold"}, bus.i_rdata, last_i);
        else if (last_d_ok) chk({tag, " d_rdata_hold"}, bus.d_rdata, last_d);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        tick();
        settle();
        chk({tag, " done_one_cycle"}, v.is_d ? bus.d_done : bus.i_done, 0);
        chk({tag, " i_done_count"}, n_idone - c0i, v.is_d ? 0 : 1);
        chk({tag, " d_done_count"}, n_ddone - c0d, v.is_d ? 1 : 0);
        if (v.is_d) begin
            last_d    = v.exp_rdata;
            last_d_ok = !v.wr;
        end else begin
            last_i = v.exp_rdata;
        end
        tick();
    endtask

    vec_t vecs[5];
    vec_t v;
    int   c0i;
    int   c0d;

    initial begin
        //        is_d wr  addr      wdata     lat mrdata    exp_wr exp_rdata
        vecs[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 3, 16'hBEEF, 1'b0, 16'hBEEF};
        vecs[1] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 1, 16'h1111, 1'b0, 16'h1111};
        vecs[2] = '{1'b1, 1'b1, 16'h0010, 16'h1234, 2, 16'h0000, 1'b1, 16'h0000};
        vecs[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 5, 16'hA5A5, 1'b0, 16'hA5A5};
        vecs[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1, 16'h5A5A, 1'b0, 16'h5A5A};
        last_i    = 16'h0000;
        last_d    = 16'h0000;
        last_d_ok = 1'b1;

        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk("rst mem_en", bus.mem_en, 0);
        chk("rst mem_wr", bus.mem_wr, 0);
        chk("rst mem_addr", bus.mem_addr, 0);
        chk("rst mem_wdata", bus.mem_wdata, 0);
        chk("rst i_rdata", bus.i_rdata, 0);
        chk("rst d_rdata", bus.d_rdata, 0);
        chk("rst i_done", bus.i_done, 0);
        chk("rst d_done", bus.d_done, 0);
        chk("rst err", bus.err, 0);
        chk("rst stalls", {bus.i_stall, bus.d_stall}, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        for (int n = 0; n < 5; n++) begin
            run_access(vecs[n], $sformatf("vec%0d", n));
        end

        // Simultaneous requests: D store first, I fetch on the next IDLE
        c0i = n_idone;
        c0d = n_ddone;
        bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0010; bus.d_wdata = 16'h1234;
        bus.i_req = 1'b1; bus.i_addr = 16'h0200;
        tick();
        settle();
        chk("both mem_en", bus.mem_en, 1);
        chk("both mem_wr", bus.mem_wr, 1);
        chk("both mem_addr", bus.mem_addr, 16'h0010);
        chk("both mem_wdata", bus.mem_wdata, 16'h1234);
        tick();
        bus.mem_done = 1'b1;
        tick();
        bus.mem_done = 1'b0;
        settle();
        chk("both d_done", bus.d_done, 1);
        chk("both i_done_early", bus.i_done, 0);
        chk("both i_stall", bus.i_stall, 1);
        bus.d_req = 1'b0;
        tick();
        settle();
        chk("both idle_gap", bus.mem_en, 0);
        tick();
        settle();
        chk("both i mem_en", bus.mem_en, 1);
        chk("both i mem_wr", bus.mem_wr, 0);
        chk("both i mem_addr", bus.mem_addr, 16'h0200);
        tick();
        bus.mem_done = 1'b1; bus.mem_rdata = 16'h7777;
        tick();
        bus.mem_done = 1'b0;
        settle();
        chk("both i_done", bus.i_done, 1);
        chk("both i_rdata", bus.i_rdata, 16'h7777);
        bus.i_req = 1'b0;
        tick();
        settle();
        chk("both i_done_count", n_idone - c0i, 1);
        chk("both d_done_count", n_ddone - c0d, 1);
        last_i    = 16'h7777;
        last_d_ok = 1'b0;
        tick();

        // Flush during WAIT of a fetch
        c0i = n_idone;
        bus.i_req = 1'b1; bus.i_addr = 16'h0100;
        tick();
        settle();
        chk("flush mem_en", bus.mem_en, 1);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; bus.i_req = 1'b0;
        bus.mem_done = 1'b1; bus.mem_rdata = 16'hDEAD;
        tick();
        bus.mem_done = 1'b0;
        settle();
        chk("flush no_i_done", bus.i_done, 0);
        chk("flush i_rdata_hold", bus.i_rdata, last_i);
        chk("flush mem_en_resp", bus.mem_en, 0);
        tick();
        settle();
        chk("flush i_done_count", n_idone - c0i, 0);
        tick();
        v = '{1'b0, 1'b0, 16'h0104, 16'h0000, 2, 16'h2468, 1'b0, 16'h2468};
        run_access(v, "post_flush");

        // Stray mem_done in IDLE and ISSUE
        c0d = n_ddone;
        bus.mem_done = 1'b1; bus.mem_rdata = 16'hBAD0;
        tick();
        settle();
        chk("stray idle mem_en", bus.mem_en, 0);
        chk("stray idle done", {bus.i_done, bus.d_done}, 0);
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0300;
        tick();
        settle();
        chk("stray issue mem_en", bus.mem_en, 1);
        tick();
        bus.mem_done = 1'b0;
        settle();
        chk("stray no_d_done", bus.d_done, 0);
        tick();
        bus.mem_done = 1'b1; bus.mem_rdata = 16'h4321;
        settle();
        chk("stray still_waiting", bus.d_done, 0);
        tick();
        bus.mem_done = 1'b0;
        settle();
        chk("stray d_done", bus.d_done, 1);
        chk("stray d_rdata", bus.d_rdata, 16'h4321);
        bus.d_req = 1'b0;
        tick();
        settle();
        chk("stray d_done_count", n_ddone - c0d, 1);
        last_d    = 16'h4321;
        last_d_ok = 1'b1;
        tick();

        // Watchdog timeout on a D load
        c0i = n_idone;
        c0d = n_ddone;
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0600;
        tick();
        tick();
        for (int k = 1; k <= TMO; k++) begin
            settle();
            if (k == TMO) chk("tmo err_before", bus.err, 0);
            tick();
        end
        bus.d_req = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 16'h0700;
        settle();
        chk("tmo err_set", bus.err, 1);
        chk("tmo no_d_done", bus.d_done, 0);
        tick();
        settle();
        chk("tmo idle_reissue", bus.mem_en, 1);
        chk("tmo reissue_addr", bus.mem_addr, 16'h0700);
        tick();
        bus.mem_done = 1'b1; bus.mem_rdata = 16'h0707;
        tick();
        bus.mem_done = 1'b0;
        settle();
        chk("tmo i_done", bus.i_done, 1);
        chk("tmo i_rdata", bus.i_rdata, 16'h0707);
        chk("tmo err_sticky", bus.err, 1);
        bus.i_req = 1'b0;
        tick();
        settle();
        chk("tmo d_done_count", n_ddone - c0d, 0);
        chk("tmo i_done_count", n_idone - c0i, 1);
        tick();

        // Reset during WAIT of a D store
        c0d = n_ddone;
        bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0020; bus.d_wdata = 16'h9999;
        tick();
        settle();
        chk("rstw mem_wr", bus.mem_wr, 1);
        tick();
        settle();
        rst_n = 1'b0;
        bus.d_req = 1'b0;
        #1;
        chk("rstw mem_en", bus.mem_en, 0);
        chk("rstw mem_wr_clr", bus.mem_wr, 0);
        chk("rstw mem_addr", bus.mem_addr, 0);
        chk("rstw mem_wdata", bus.mem_wdata, 0);
        chk("rstw rdata", {bus.i_rdata, bus.d_rdata}, 0);
        chk("rstw err_clr", bus.err, 0);
        chk("rstw done", {bus.i_done, bus.d_done}, 0);
        tick();
        rst_n = 1'b1;
        bus.mem_done = 1'b1; bus.mem_rdata = 16'hEEEE;
        tick();
        bus.mem_done = 1'b0;
        settle();
        chk("rstw late_done", bus.d_done, 0);
        chk("rstw late_mem_en", bus.mem_en, 0);
        tick();
        chk("rstw d_done_count", n_ddone - c0d, 0);
        last_i    = 16'h0000;
        last_d    = 16'h0000;
        last_d_ok = 1'b1;
        v = '{1'b1, 1'b0, 16'h0030, 16'h0000, 1, 16'hC0DE, 1'b0, 16'hC0DE};
        run_access(v, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
